multicycle_control: RTL and testbench

- Moore-style multicycle control FSM for the MIPS-subset datapath.
- Drives every datapath mux select and register write-enable, including the 3-bit ALU source-B select consumed by the ALU operand-B mux.
- Sequences fetch, decode, execute, memory and write-back per opcode.
- Sits between the instruction register (opcode/funct) and the datapath; inserts wait cycles for a fixed-latency memory.

---
 rtl/control_pkg.sv | 71 +++++++
 rtl/control_wait_counter.sv | 29 ++
 rtl/multicycle_control.sv | 158 +++++++++++++++
 tb/tb_multicycle_control.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// Shared state, opcode/funct and datapath select encodings for the multicycle control FSM.
package control_pkg;

    typedef enum logic [3:0] {
        StReset,
        StFetch,
        StDecode,
        StRExec,
        StRWb,
        StAddiExec,
        StAddiWb,
        StMemAddr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StBranch,
        StJump,
        StExcept,
        StIllegal
    } state_t;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    // R-type funct codes (IR[5:0])
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;

    // ALU operation encodings
    localparam logic [2:0] ALU_NONE = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;

    // ALU operand-B mux selects
    localparam logic [2:0] SRC_B_REG     = 3'b000;
    localparam logic [2:0] SRC_B_FOUR    = 3'b001;
    localparam logic [2:0] SRC_B_IMM     = 3'b010;
    localparam logic [2:0] SRC_B_IMM_SL2 = 3'b011;
    localparam logic [2:0] SRC_B_A       = 3'b100;

    // PC source mux selects
    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    // Supported R-type funct codes
    function automatic logic funct_legal(input logic [5:0] fn);
        return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND);
    endfunction

    // ALU operation for an R-type funct code
    function automatic logic [2:0] funct_alu_op(input logic [5:0] fn);
        logic [2:0] op;
        op = ALU_NONE;
        case (fn)
            FN_ADD:  op = ALU_ADD;
            FN_SUB:  op = ALU_SUB;
            FN_AND:  op = ALU_AND;
            default: op = ALU_NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/control_wait_counter.sv
// Wait-cycle counter for fixed-latency memory accesses; done when count reaches MEM_WAIT.
module control_wait_counter
    import control_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic done
);

    logic [2:0] count_q;

    // Count up while enabled; clear wins over enable, saturate at MEM_WAIT
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= 3'd0;
        end else if (clear) begin
            count_q <= 3'd0;
        end else if (enable && !done) begin
            count_q <= count_q + 3'd1;
        end
    end

    assign done = (count_q == 3'(MEM_WAIT));

endmodule

// File: rtl/multicycle_control.sv
// Moore multicycle control FSM for the MIPS-subset datapath.
module multicycle_control
    import control_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       overflow,
    output logic       pc_write,
    output logic       pc_cond_write,
    output logic [1:0] pc_source_sel,
    output logic       mem_addr_sel,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mdr_write,
    output logic       ab_write,
    output logic       alu_out_write,
    output logic       alu_src_a_sel,
    output logic [2:0] alu_src_b_sel,
    output logic [2:0] alu_op,
    output logic       reg_write,
    output logic       reg_dst_sel,
    output logic       mem_to_reg_sel,
    output logic       overflow_exc,
    output logic       illegal_op
);

    state_t state_q, state_d;
    logic   wait_done;
    logic   unused_zero;

    // zero is consumed by the datapath together with pc_cond_write
    assign unused_zero = zero;

    control_wait_counter #(
        .MEM_WAIT (MEM_WAIT)
    ) u_wait (
        .clk    (clk),
        .reset  (reset),
        .clear  (state_d != state_q),
        .enable ((state_q == StFetch) || (state_q == StMemRead)),
        .done   (wait_done)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StReset;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; overflow only matters in the two execute states
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StReset:  state_d = StFetch;
            StFetch:  if (wait_done) state_d = StDecode;
            StDecode: begin
                case (opcode)
                    OP_RTYPE:     state_d = funct_legal(funct) ? StRExec : StIllegal;
                    OP_ADDI:      state_d = StAddiExec;
                    OP_LW, OP_SW: state_d = StMemAddr;
                    OP_BEQ:       state_d = StBranch;
                    OP_J:         state_d = StJump;
                    default:      state_d = StIllegal;
                endcase
            end
            StRExec:    state_d = (overflow && (funct != FN_AND)) ? StExcept : StRWb;
            StAddiExec: state_d = overflow ? StExcept : StAddiWb;
            StMemAddr:  state_d = (opcode == OP_LW) ? StMemRead : StMemWrite;
            StMemRead:  if (wait_done) state_d = StMemWb;
            default:    state_d = StFetch;
        endcase
    end

    // Output decode from state (plus wait counter for the final FETCH/MEM_READ cycle)
    always_comb begin
        pc_write       = 1'b0;
        pc_cond_write  = 1'b0;
        pc_source_sel  = PC_SRC_ALU;
        mem_addr_sel   = 1'b0;
        mem_write      = 1'b0;
        ir_write       = 1'b0;
        mdr_write      = 1'b0;
        ab_write       = 1'b0;
        alu_out_write  = 1'b0;
        alu_src_a_sel  = 1'b0;
        alu_src_b_sel  = SRC_B_REG;
        alu_op         = ALU_NONE;
        reg_write      = 1'b0;
        reg_dst_sel    = 1'b0;
        mem_to_reg_sel = 1'b0;
        overflow_exc   = 1'b0;
        illegal_op     = 1'b0;
        unique case (state_q)
            StFetch: begin
                alu_src_b_sel = SRC_B_FOUR;
                alu_op        = ALU_ADD;
                ir_write      = wait_done;
                pc_write      = wait_done;
            end
            StDecode: begin
                ab_write      = 1'b1;
                alu_src_b_sel = SRC_B_IMM_SL2;
                alu_op        = ALU_ADD;
                alu_out_write = 1'b1;
            end
            StRExec: begin
                alu_src_a_sel = 1'b1;
                alu_op        = funct_alu_op(funct);
                alu_out_write = 1'b1;
            end
            StRWb: begin
                reg_write   = 1'b1;
                reg_dst_sel = 1'b1;
            end
            StAddiExec, StMemAddr: begin
                alu_src_a_sel = 1'b1;
                alu_src_b_sel = SRC_B_IMM;
                alu_op        = ALU_ADD;
                alu_out_write = 1'b1;
            end
            StAddiWb: reg_write = 1'b1;
            StMemRead: begin
                mem_addr_sel = 1'b1;
                mdr_write    = wait_done;
            end
            StMemWb: begin
                reg_write      = 1'b1;
                mem_to_reg_sel = 1'b1;
            end
            StMemWrite: begin
                mem_addr_sel = 1'b1;
                mem_write    = 1'b1;
            end
            StBranch: begin
                alu_src_a_sel = 1'b1;
                alu_op        = ALU_SUB;
                pc_cond_write = 1'b1;
                pc_source_sel = PC_SRC_ALUOUT;
            end
            StJump: begin
                pc_write      = 1'b1;
                pc_source_sel = PC_SRC_JUMP;
            end
            StExcept:  overflow_exc = 1'b1;
            StIllegal: illegal_op = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench: the driver pushes the expected per-cycle control vector,
// a monitor pops and compares it at each falling edge.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode, funct;
    logic       zero, overflow;

    logic       pc_write, pc_cond_write, mem_addr_sel, mem_write, ir_write, mdr_write;
    logic       ab_write, alu_out_write, alu_src_a_sel, reg_write, reg_dst_sel;
    logic       mem_to_reg_sel, overflow_exc, illegal_op;
    logic [1:0] pc_source_sel;
    logic [2:0] alu_src_b_sel, alu_op;

    logic       pc_write0, pc_cond_write0, mem_addr_sel0, mem_write0, ir_write0, mdr_write0;
    logic       ab_write0, alu_out_write0, alu_src_a_sel0, reg_write0, reg_dst_sel0;
    logic       mem_to_reg_sel0, overflow_exc0, illegal_op0;
    logic [1:0] pc_source_sel0;
    logic [2:0] alu_src_b_sel0, alu_op0;

    logic [21:0] vec, vec0;
    logic [21:0] q[$], q0[$];
    string       qn[$], qn0[$];
    bit          sel = 1'b0;
    int          total = 0;
    int          bad = 0;

    logic [21:0] z, f0, fl, dec, rex_add, rex_sub, rex_and, rwb, aex, awb;
    logic [21:0] mr0, mrl, mwb, mwr, br, jmp, exc, ill;

    always #5 clk = ~clk;

    multicycle_control #(.MEM_WAIT(2)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .overflow(overflow), .pc_write(pc_write), .pc_cond_write(pc_cond_write),
        .pc_source_sel(pc_source_sel), .mem_addr_sel(mem_addr_sel), .mem_write(mem_write),
        .ir_write(ir_write), .mdr_write(mdr_write), .ab_write(ab_write),
        .alu_out_write(alu_out_write), .alu_src_a_sel(alu_src_a_sel),
        .alu_src_b_sel(alu_src_b_sel), .alu_op(alu_op), .reg_write(reg_write),
        .reg_dst_sel(reg_dst_sel), .mem_to_reg_sel(mem_to_reg_sel),
        .overflow_exc(overflow_exc), .illegal_op(illegal_op)
    );

    multicycle_control #(.MEM_WAIT(0)) dut0 (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .overflow(overflow), .pc_write(pc_write0), .pc_cond_write(pc_cond_write0),
        .pc_source_sel(pc_source_sel0), .mem_addr_sel(mem_addr_sel0),
        .mem_write(mem_write0), .ir_write(ir_write0), .mdr_write(mdr_write0),
        .ab_write(ab_write0), .alu_out_write(alu_out_write0),
        .alu_src_a_sel(alu_src_a_sel0), .alu_src_b_sel(alu_src_b_sel0), .alu_op(alu_op0),
        .reg_write(reg_write0), .reg_dst_sel(reg_dst_sel0),
        .mem_to_reg_sel(mem_to_reg_sel0), .overflow_exc(overflow_exc0),
        .illegal_op(illegal_op0)
    );

    assign vec = {pc_write, pc_cond_write, pc_source_sel, mem_addr_sel, mem_write, ir_write,
                  mdr_write, ab_write, alu_out_write, alu_src_a_sel, alu_src_b_sel, alu_op,
                  reg_write, reg_dst_sel, mem_to_reg_sel, overflow_exc, illegal_op};
    assign vec0 = {pc_write0, pc_cond_write0, pc_source_sel0, mem_addr_sel0, mem_write0,
                   ir_write0, mdr_write0, ab_write0, alu_out_write0, alu_src_a_sel0,
                   alu_src_b_sel0, alu_op0, reg_write0, reg_dst_sel0, mem_to_reg_sel0,
                   overflow_exc0, illegal_op0};

    function automatic logic [21:0] pk(
        input logic pcw, input logic pccw, input logic [1:0] pcs, input logic mas,
        input logic mw, input logic irw, input logic mdrw, input logic abw, input logic aow,
        input logic sa, input logic [2:0] sb, input logic [2:0] op, input logic rw,
        input logic rd, input logic m2r, input logic oe, input logic il);
        return {pcw, pccw, pcs, mas, mw, irw, mdrw, abw, aow, sa, sb, op, rw, rd, m2r, oe, il};
    endfunction

    // Monitor: compare whatever the driver expects for this cycle
    always @(negedge clk) begin
        logic [21:0] e;
        string       nm;
        if (q.size() > 0) begin
            e  = q.pop_front();
            nm = qn.pop_front();
            total++;
            if (vec !== e) begin
                bad++;
                $display("FAIL %s (MEM_WAIT=2) @%0t: got %b want %b", nm, $time, vec, e);
            end
        end
        if (q0.size() > 0) begin
            e  = q0.pop_front();
            nm = qn0.pop_front();
            total++;
            if (vec0 !== e) begin
                bad++;
                $display("FAIL %s (MEM_WAIT=0) @%0t: got %b want %b", nm, $time, vec0, e);
            end
        end
    end

    // One clock: drive reset/overflow just after the edge, push expected outputs
    task automatic cyc(input logic r, input logic ov, input logic [21:0] e, input string nm);
        @(posedge clk);
        #1;
        reset    = r;
        overflow = ov;
        if (!sel) begin
            q.push_back(e);
            qn.push_back(nm);
        end else begin
            q0.push_back(e);
            qn0.push_back(nm);
        end
    endtask

    // Fetch (nw wait cycles + final) and decode; overflow held high as it must be ignored
    task automatic fd(input logic [5:0] op, input logic [5:0] fn, input int nw);
        opcode = op;
        funct  = fn;
        for (int i = 0; i < nw; i++) cyc(1'b0, 1'b1, f0, "fetch");
        cyc(1'b0, 1'b1, fl, "fetch_last");
        cyc(1'b0, 1'b1, dec, "decode");
    endtask

    initial begin
        reset    = 1'b1;
        opcode   = 6'h00;
        funct    = 6'h00;
        zero     = 1'b0;
        overflow = 1'b0;

        z       = '0;
        f0      = pk(0,0,2'b00,0,0,0,0,0,0,0,3'b001,3'b001,0,0,0,0,0);
        fl      = pk(1,0,2'b00,0,0,1,0,0,0,0,3'b001,3'b001,0,0,0,0,0);
        dec     = pk(0,0,2'b00,0,0,0,0,1,1,0,3'b011,3'b001,0,0,0,0,0);
        rex_add = pk(0,0,2'b00,0,0,0,0,0,1,1,3'b000,3'b001,0,0,0,0,0);
        rex_sub = pk(0,0,2'b00,0,0,0,0,0,1,1,3'b000,3'b010,0,0,0,0,0);
        rex_and = pk(0,0,2'b00,0,0,0,0,0,1,1,3'b000,3'b011,0,0,0,0,0);
        rwb     = pk(0,0,2'b00,0,0,0,0,0,0,0,3'b000,3'b000,1,1,0,0,0);
        aex     = pk(0,0,2'b00,0,0,0,0,0,1,1,3'b010,3'b001,0,0,0,0,0);
        awb     = pk(0,0,2'b00,0,0,0,0,0,0,0,3'b000,3'b000,1,0,0,0,0);
        mr0     = pk(0,0,2'b00,1,0,0,0,0,0,0,3'b000,3'b000,0,0,0,0,0);
        mrl     = pk(0,0,2'b00,1,0,0,1,0,0,0,3'b000,3'b000,0,0,0,0,0);
        mwb     = pk(0,0,2'b00,0,0,0,0,0,0,0,3'b000,3'b000,1,0,1,0,0);
        mwr     = pk(0,0,2'b00,1,1,0,0,0,0,0,3'b000,3'b000,0,0,0,0,0);
        br      = pk(0,1,2'b01,0,0,0,0,0,0,1,3'b000,3'b010,0,0,0,0,0);
        jmp     = pk(1,0,2'b10,0,0,0,0,0,0,0,3'b000,3'b000,0,0,0,0,0);
        exc     = pk(0,0,2'b00,0,0,0,0,0,0,0,3'b000,3'b000,0,0,0,1,0);
        ill     = pk(0,0,2'b00,0,0,0,0,0,0,0,3'b000,3'b000,0,0,0,0,1);

        // Reset, release, then reset again in the middle of FETCH
        cyc(1'b1, 1'b0, z, "reset");
        cyc(1'b1, 1'b0, z, "reset_hold");
        cyc(1'b0, 1'b0, z, "reset_release");
        cyc(1'b0, 1'b0, f0, "fetch1");
        cyc(1'b0, 1'b0, f0, "fetch2");
        cyc(1'b1, 1'b0, z, "reset_mid_fetch");
        cyc(1'b1, 1'b0, z, "reset_mid_hold");
        cyc(1'b0, 1'b0, z, "reset_release2");

        // add, no overflow
        fd(6'h00, 6'h20, 2);
        cyc(1'b0, 1'b0, rex_add, "r_exec_add");
        cyc(1'b0, 1'b1, rwb, "r_wb_add");
        // sub with overflow -> exception
        fd(6'h00, 6'h22, 2);
        cyc(1'b0, 1'b1, rex_sub, "r_exec_sub");
        cyc(1'b0, 1'b0, exc, "except_sub");
        // and ignores overflow
        fd(6'h00, 6'h24, 2);
        cyc(1'b0, 1'b1, rex_and, "r_exec_and");
        cyc(1'b0, 1'b0, rwb, "r_wb_and");
        // addi with overflow -> exception, no register write
        fd(6'h08, 6'h00, 2);
        cyc(1'b0, 1'b1, aex, "addi_exec_ovf");
        cyc(1'b0, 1'b0, exc, "except_addi");
        // addi, no overflow
        fd(6'h08, 6'h00, 2);
        cyc(1'b0, 1'b0, aex, "addi_exec");
        cyc(1'b0, 1'b1, awb, "addi_wb");
        // lw
        fd(6'h23, 6'h00, 2);
        cyc(1'b0, 1'b1, aex, "lw_mem_addr");
        cyc(1'b0, 1'b1, mr0, "mem_read1");
        cyc(1'b0, 1'b1, mr0, "mem_read2");
        cyc(1'b0, 1'b1, mrl, "mem_read3");
        cyc(1'b0, 1'b1, mwb, "mem_wb");
        // sw
        fd(6'h2B, 6'h00, 2);
        cyc(1'b0, 1'b1, aex, "sw_mem_addr");
        cyc(1'b0, 1'b1, mwr, "mem_write");
        // beq, j
        fd(6'h04, 6'h00, 2);
        cyc(1'b0, 1'b1, br, "branch");
        fd(6'h02, 6'h00, 2);
        cyc(1'b0, 1'b1, jmp, "jump");
        // illegal opcode and illegal funct
        fd(6'h3F, 6'h00, 2);
        cyc(1'b0, 1'b1, ill, "illegal_opcode");
        fd(6'h00, 6'h25, 2);
        cyc(1'b0, 1'b1, ill, "illegal_funct");
        cyc(1'b0, 1'b0, f0, "fetch_after_illegal");

        // MEM_WAIT=0 instance: single-cycle FETCH and MEM_READ
        sel = 1'b1;
        cyc(1'b1, 1'b0, z, "w0_reset");
        cyc(1'b0, 1'b0, z, "w0_release");
        fd(6'h02, 6'h00, 0);
        cyc(1'b0, 1'b0, jmp, "w0_jump");
        fd(6'h23, 6'h00, 0);
        cyc(1'b0, 1'b0, aex, "w0_mem_addr");
        cyc(1'b0, 1'b0, mrl, "w0_mem_read");
        cyc(1'b0, 1'b0, mwb, "w0_mem_wb");
        cyc(1'b0, 1'b0, fl, "w0_fetch");

        @(posedge clk);
        @(negedge clk);
        #1;
        total++;
        if (q.size() + q0.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d left want 0", q.size() + q0.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
